// File: rtl/flags_unit_pkg.sv
// Shared definitions for the 8086 FLAGS register, the Jcc condition decoder
// and the single-step trap sequencer.
package flags_unit_pkg;

  // Flag bit positions, matching the ALU flag vector.
  localparam int CF_IDX = 0;
  localparam int PF_IDX = 2;
  localparam int AF_IDX = 4;
  localparam int ZF_IDX = 6;
  localparam int SF_IDX = 7;
  localparam int TF_IDX = 8;
  localparam int IF_IDX = 9;
  localparam int DF_IDX = 10;
  localparam int OF_IDX = 11;

  localparam logic [15:0] FLAGS_WRITABLE_MASK = 16'h0FD5;
  localparam logic [15:0] FLAGS_FIXED_ONES    = 16'hF002;
  localparam logic [15:0] FLAGS_FIXED_ZEROS   = 16'h0028;

  // Jcc condition field, x86 encoding; odd codes invert the even code's test.
  typedef enum logic [3:0] {
    JCC_O  = 4'h0,
    JCC_NO = 4'h1,
    JCC_B  = 4'h2,
    JCC_AE = 4'h3,
    JCC_E  = 4'h4,
    JCC_NE = 4'h5,
    JCC_BE = 4'h6,
    JCC_A  = 4'h7,
    JCC_S  = 4'h8,
    JCC_NS = 4'h9,
    JCC_P  = 4'hA,
    JCC_NP = 4'hB,
    JCC_L  = 4'hC,
    JCC_GE = 4'hD,
    JCC_LE = 4'hE,
    JCC_G  = 4'hF
  } jcc_cond_e;

  // Trap state encodings kept as plain constants so older decode logic can
  // compare against them directly.
  localparam logic [1:0] TRAP_IDLE_ENC    = 2'b00;
  localparam logic [1:0] TRAP_ARMED_ENC   = 2'b01;
  localparam logic [1:0] TRAP_PENDING_ENC = 2'b10;

  typedef enum logic [1:0] {
    TRAP_IDLE    = TRAP_IDLE_ENC,
    TRAP_ARMED   = TRAP_ARMED_ENC,
    TRAP_PENDING = TRAP_PENDING_ENC
  } trap_state_e;

  // Forces the architecturally fixed bits to their read values.
  function automatic logic [15:0] apply_fixed_bits(input logic [15:0] f);
    return (f | FLAGS_FIXED_ONES) & ~FLAGS_FIXED_ZEROS;
  endfunction

  // Merges a masked update into the current flags, honouring only writable bits.
  function automatic logic [15:0] merge_flags(input logic [15:0] cur,
                                              input logic [15:0] upd,
                                              input logic [15:0] mask);
    logic [15:0] m;
    m = mask & FLAGS_WRITABLE_MASK;
    return (cur & ~m) | (upd & m);
  endfunction

endpackage

// File: rtl/flags_cond_eval.sv
// Combinational Jcc condition decoder; shared with the prefetch/branch logic.
module flags_cond_eval
  import flags_unit_pkg::*;
(
  input  logic       cf,
  input  logic       pf,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic base;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    base = 1'b0;
    case (jcc_cond_e'({cond[3:1], 1'b0}))
      JCC_O:   base = of;
      JCC_B:   base = cf;
      JCC_E:   base = zf;
      JCC_BE:  base = cf | zf;
      JCC_S:   base = sf;
      JCC_P:   base = pf;
      JCC_L:   base = sf ^ of;
      JCC_LE:  base = zf | (sf ^ of);
      default: base = 1'b0;
    endcase
  end

  assign cond_true = base ^ cond[0];

endmodule

// File: rtl/flags_unit.sv
// Architectural FLAGS register with Jcc evaluation, single-step trap
// sequencing and the one-instruction interrupt shadow.
module flags_unit
  import flags_unit_pkg::*;
#(
  parameter logic [15:0] RESET_FLAGS = 16'hF002
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] alu_flags,
  input  logic        update_valid,
  input  logic [15:0] update_mask,
  input  logic        int_entry,
  input  logic        instr_start,
  input  logic        instr_done,
  input  logic        shadow_set,
  input  logic        trap_ack,
  input  logic [3:0]  cond,
  output logic [15:0] flags,
  output logic        cond_true,
  output logic        trap_req,
  output logic        intr_allowed
);

  logic [15:0] flags_q;
  logic [15:0] flags_nxt;
  trap_state_e state_q;
  trap_state_e state_nxt;
  logic        shadow_q;
  logic        shadow_active_q;
  logic        shadow_eff;
  logic        shadow_active_nxt;
  logic        intr_allowed_q;

  always_comb begin
    flags_nxt = flags_q;
    if (update_valid) begin
      flags_nxt = merge_flags(flags_q, alu_flags, update_mask);
    end
    // Interrupt entry wins over the ALU for TF/IF only.
    if (int_entry) begin
      flags_nxt[TF_IDX] = 1'b0;
      flags_nxt[IF_IDX] = 1'b0;
    end
    flags_nxt = apply_fixed_bits(flags_nxt);
  end

  // A shadow opened in the same cycle the instruction ends still belongs to it.
  assign shadow_eff        = shadow_q | shadow_set;
  assign shadow_active_nxt = instr_done ? shadow_eff : shadow_active_q;

  // TF is sampled from the committed flags at instruction start, so the
  // instruction that sets TF is not itself traced.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TRAP_IDLE: begin
        if (instr_start && flags_q[TF_IDX]) begin
          state_nxt = TRAP_ARMED;
        end
      end
      TRAP_ARMED: begin
        if (instr_done) begin
          state_nxt = shadow_eff ? TRAP_IDLE : TRAP_PENDING;
        end
      end
      TRAP_PENDING: begin
        if (trap_ack) begin
          state_nxt = TRAP_IDLE;
        end
      end
      default: state_nxt = TRAP_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q         <= RESET_FLAGS;
      state_q         <= TRAP_IDLE;
      shadow_q        <= 1'b0;
      shadow_active_q <= 1'b0;
      intr_allowed_q  <= 1'b0;
    end else begin
      flags_q         <= flags_nxt;
      state_q         <= state_nxt;
      shadow_active_q <= shadow_active_nxt;
      if (instr_done) begin
        shadow_q <= 1'b0;
      end else if (shadow_set) begin
        shadow_q <= 1'b1;
      end
      // Computed from next-state values so it matches the registers it describes.
      intr_allowed_q <= flags_nxt[IF_IDX] & ~shadow_active_nxt
                        & (state_nxt != TRAP_PENDING);
    end
  end

  flags_cond_eval u_cond_eval (
    .cf        (flags_q[CF_IDX]),
    .pf        (flags_q[PF_IDX]),
    .zf        (flags_q[ZF_IDX]),
    .sf        (flags_q[SF_IDX]),
    .of        (flags_q[OF_IDX]),
    .cond      (cond),
    .cond_true (cond_true)
  );

  assign flags        = flags_q;
  assign trap_req     = (state_q == TRAP_PENDING);
  assign intr_allowed = intr_allowed_q;

endmodule

// File: doc/flags_unit.md
Name: flags_unit

Overview:
- Architectural FLAGS register for the 8086 core.
- Consumes the ALU's flag result and per-flag update mask, and feeds the stored FLAGS back to the ALU's flags input.
- Evaluates Jcc conditions.
- Sequences single-step trap requests and the one-instruction interrupt shadow (MOV SS / POP SS / STI) for the microcode sequencer.

Parameters:
- RESET_FLAGS, 16'hF002, FLAGS value after reset; bits 15:12 and 1 read as 1, bits 5 and 3 read as 0.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- alu_flags  in  16  flag result from the ALU
- update_valid  in  1  commit alu_flags under update_mask this cycle
- update_mask  in  16  per-bit write enable; only CF0, PF2, AF4, ZF6, SF7, TF8, IF9, DF10, OF11 are honoured
- int_entry  in  1  interrupt/trap entry: clear TF and IF
- instr_start  in  1  pulse on the first microcode cycle of an instruction
- instr_done  in  1  pulse on the last microcode cycle of an instruction
- shadow_set  in  1  current instruction opens an interrupt shadow
- trap_ack  in  1  sequencer has begun the INT 1 sequence
- cond  in  4  Jcc condition code, x86 encoding 0=O .. F=G
- flags  out  16  registered FLAGS; drives the ALU flags input
- cond_true  out  1  condition result, combinational from flags and cond
- trap_req  out  1  single-step trap pending
- intr_allowed  out  1  maskable interrupts may be taken at this boundary

Behaviour:
- Reset: flags=RESET_FLAGS, trap FSM=IDLE, shadow_q=0, shadow_active=0, trap_req=0, intr_allowed=0 (IF=0).
- FLAGS update is registered; new value is visible the cycle after update_valid (1-cycle latency). There is no bypass.
  - Equation: flags_next = (flags & ~m) | (alu_flags & m), where m = update_mask & 16'h0FD5.
  - Fixed bits are forced every cycle: bits 15:12=1, bit 1=1, bits 5 and 3=0.
- int_entry forces TF=0 and IF=0 next cycle. It overrides update_valid for those two bits only; other bits still update.
- cond_true, with c = cond[0] inverting the sense:
  - pairs 0/1 OF; 2/3 CF; 4/5 ZF; 6/7 CF|ZF; 8/9 SF; A/B PF; C/D SF^OF; E/F ZF|(SF^OF).
- Trap FSM, states IDLE, ARMED, PENDING:
  - IDLE -> ARMED on instr_start when flags.TF=1. TF is sampled at instruction start, so the instruction that sets TF does not trap.
  - ARMED -> IDLE on instr_done when shadow_q=1 (trap suppressed by shadow).
  - ARMED -> PENDING on instr_done otherwise.
  - PENDING: trap_req=1, registered; held until trap_ack; trap_ack -> IDLE.
  - trap_ack while not PENDING is ignored.
  - trap_ack and instr_start in the same cycle: go to IDLE; do not re-arm, since int_entry clears TF.
- Shadow:
  - shadow_set sets shadow_q; shadow_q is cleared at instr_done.
  - At that instr_done, shadow_active <= shadow_q.
  - shadow_active clears on the next instr_done.
  - shadow_set and instr_done in the same cycle count as set within the current instruction.
- intr_allowed = IF & ~shadow_active & (state!=PENDING); registered output.
- Reset at any point, including in PENDING or mid-shadow, returns to the reset values above in the next cycle.

Decomposition:
- Shared package: flag bit-index constants (CF_IDX..OF_IDX) matching the ALU, FLAGS_WRITABLE_MASK=16'h0FD5, the 4-bit Jcc condition enum, and the trap-state enum.
- One sub-module: flags_cond_eval (combinational condition decoder), reusable by the prefetch/branch logic.

Test Plan:
- Reset: assert reset 2 cycles -> flags=16'hF002, trap_req=0, intr_allowed=0.
- Masked update:
  - Stimulus: flags=F002, alu_flags=FFFF, update_mask=0x0041 (CF|ZF), update_valid -> next cycle flags=F043.
  - Stimulus: update_mask=FFFF -> flags=FFD7.
- Conditions:
  - With SF=1, OF=0, ZF=0: cond=C (L) -> 1; cond=F (G) -> 0.
  - With ZF=1: cond=6 (BE) -> 1; cond=7 (A) -> 0.
- Single step:
  - Set TF via update, then instr_start, instr_done -> trap_req=1 next cycle.
  - Hold 5 cycles -> still 1.
  - trap_ack with int_entry -> trap_req=0, TF=0, IF=0.
  - Instruction that sets TF produces no trap.
- Shadow:
  - IF=1; instruction with shadow_set then instr_done -> intr_allowed=0 through the next instruction, 1 after its instr_done.
  - With TF=1 and ARMED, shadow_set suppresses trap_req.
- Reset mid-PENDING: trap_req=1, assert reset -> next cycle trap_req=0, flags=F002; a later trap_ack is ignored.
